// File: rtl/const_issue_stage_pkg.sv
// Shared definitions for the constant-class issue stage.
// Holds the format codes, the instruction field bit positions and the stage FSM states.
package const_issue_stage_pkg;

    // Constant-class formats. The other two codes are not constant-class instructions.
    localparam logic [1:0] FMT_LIT  = 2'b01;  // load literal, imm11 sign-extended
    localparam logic [1:0] FMT_BYTE = 2'b11;  // lcl/lch, k8 into one byte lane

    // Instruction field positions
    localparam int unsigned FMT_HI = 15;
    localparam int unsigned FMT_LO = 14;
    localparam int unsigned RD_HI  = 13;
    localparam int unsigned RD_LO  = 11;
    localparam int unsigned IMM_HI = 10;  // imm11 occupies [10:0]
    localparam int unsigned R_BIT  = 10;  // byte select in byte format
    localparam int unsigned K8_HI  = 7;
    localparam int unsigned K8_LO  = 0;

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        ISSUE
    } state_t;

endpackage

// File: rtl/const_issue_stage_if.sv
// Bundle of handshake and bus signals around the constant issue stage.
//   instr/instr_valid/instr_ready : instruction input handshake
//   rf_rd_*                       : register-bank read port (req held until ack)
//   dado/constante/formato/R/dest : operand bundle for the constant ALU
//   op_valid/op_ready             : bundle handshake
//   illegal/rd_timeout            : one-cycle event pulses
// Modport master is the stage itself; slave is its surroundings.
interface const_issue_stage_if #(
    parameter int unsigned bits_palavra = 16,
    parameter int unsigned REG_ADDR_W   = 3
);
    logic [bits_palavra-1:0] instr;
    logic                    instr_valid;
    logic                    instr_ready;

    logic [REG_ADDR_W-1:0]   rf_rd_addr;
    logic                    rf_rd_req;
    logic                    rf_rd_ack;
    logic [bits_palavra-1:0] rf_rd_data;

    logic [bits_palavra-1:0] dado;
    logic [bits_palavra-1:0] constante;
    logic [1:0]              formato;
    logic                    R;
    logic [REG_ADDR_W-1:0]   dest;
    logic                    op_valid;
    logic                    op_ready;

    logic                    illegal;
    logic                    rd_timeout;

    modport master (
        input  instr, instr_valid, rf_rd_ack, rf_rd_data, op_ready,
        output instr_ready, rf_rd_addr, rf_rd_req, dado, constante, formato, R, dest,
               op_valid, illegal, rd_timeout
    );

    modport slave (
        output instr, instr_valid, rf_rd_ack, rf_rd_data, op_ready,
        input  instr_ready, rf_rd_addr, rf_rd_req, dado, constante, formato, R, dest,
               op_valid, illegal, rd_timeout
    );

endinterface

// File: rtl/const_issue_stage_const_position.sv
// const_position: combinational constant lane positioning.
//   formato   : instruction format
//   R         : byte select (0 = low lane, 1 = high lane), byte format only
//   instr     : full instruction word
//   constante : constant already placed where the ALU expects it
module const_position
    import const_issue_stage_pkg::*;
#(
    parameter int unsigned bits_palavra = 16
) (
    input  logic [1:0]              formato,
    input  logic                    R,
    input  logic [bits_palavra-1:0] instr,
    output logic [bits_palavra-1:0] constante
);
    logic [7:0] k8;
    logic       unused_fields;

    assign k8            = instr[K8_HI:K8_LO];
    // Format and rd bits are decoded by the parent, not here.
    assign unused_fields = ^instr[FMT_HI:RD_LO];

    always_comb begin
        constante = '0;
        unique case (formato)
            FMT_LIT:  constante = {{(bits_palavra - IMM_HI - 1){instr[IMM_HI]}}, instr[IMM_HI:0]};
            FMT_BYTE: constante = R ? bits_palavra'({k8, 8'h00}) : bits_palavra'(k8);
            default:  constante = '0;
        endcase
    end

endmodule

// File: rtl/const_issue_stage.sv
// const_issue_stage: front-end stage feeding the constant ALU.
// Accepts a constant-class instruction, positions its constant, fetches the current
// destination value for byte loads, and holds the operand bundle until op_ready.
//   clk, rst : clock and synchronous active-high reset
//   bus      : handshake/bus bundle (see const_issue_stage_if)
module const_issue_stage
    import const_issue_stage_pkg::*;
#(
    parameter int unsigned bits_palavra = 16,
    parameter int unsigned REG_ADDR_W   = 3,
    parameter int unsigned RD_TIMEOUT   = 15
) (
    input logic                 clk,
    input logic                 rst,
    const_issue_stage_if.master bus
);
    localparam int unsigned      CNT_W     = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(RD_TIMEOUT);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0]   addr_q, addr_d;
    logic [bits_palavra-1:0] dado_q, dado_d;
    logic [bits_palavra-1:0] const_q, const_d;
    logic [1:0]              fmt_q, fmt_d;
    logic                    r_q, r_d;
    logic [REG_ADDR_W-1:0]   dest_q, dest_d;
    logic                    illegal_q, illegal_d;
    logic                    timeout_q, timeout_d;

    logic [1:0]              fmt_in;
    logic [REG_ADDR_W-1:0]   rd_in;
    logic                    r_in;
    logic [bits_palavra-1:0] const_in;

    assign fmt_in = bus.instr[FMT_HI:FMT_LO];
    assign rd_in  = REG_ADDR_W'(bus.instr[RD_HI:RD_LO]);
    // R only means something for byte loads; literals carry R=0.
    assign r_in   = (fmt_in == FMT_BYTE) ? bus.instr[R_BIT] : 1'b0;

    const_position #(
        .bits_palavra(bits_palavra)
    ) u_const_position (
        .formato  (fmt_in),
        .R        (r_in),
        .instr    (bus.instr),
        .constante(const_in)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        dado_d    = dado_q;
        const_d   = const_q;
        fmt_d     = fmt_q;
        r_d       = r_q;
        dest_d    = dest_q;
        illegal_d = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.instr_valid) begin
                    unique case (fmt_in)
                        FMT_LIT: begin
                            dado_d  = '0;
                            const_d = const_in;
                            fmt_d   = fmt_in;
                            r_d     = r_in;
                            dest_d  = rd_in;
                            state_d = ISSUE;
                        end
                        FMT_BYTE: begin
                            const_d = const_in;
                            fmt_d   = fmt_in;
                            r_d     = r_in;
                            dest_d  = rd_in;
                            addr_d  = rd_in;
                            state_d = RD_REQ;
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            RD_REQ: begin
                cnt_d = cnt_q + 1'b1;
                // Ack is checked first so an ack in the final allowed cycle still issues.
                if (bus.rf_rd_ack) begin
                    dado_d  = bus.rf_rd_data;
                    state_d = ISSUE;
                end else if (cnt_d == CNT_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            ISSUE: begin
                if (bus.op_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            dado_q    <= '0;
            const_q   <= '0;
            fmt_q     <= '0;
            r_q       <= 1'b0;
            dest_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            dado_q    <= dado_d;
            const_q   <= const_d;
            fmt_q     <= fmt_d;
            r_q       <= r_d;
            dest_q    <= dest_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.instr_ready = (state_q == IDLE);
    assign bus.rf_rd_req   = (state_q == RD_REQ);
    assign bus.op_valid    = (state_q == ISSUE);
    assign bus.rf_rd_addr  = addr_q;
    assign bus.dado        = dado_q;
    assign bus.constante   = const_q;
    assign bus.formato     = fmt_q;
    assign bus.R           = r_q;
    assign bus.dest        = dest_q;
    assign bus.illegal     = illegal_q;
    assign bus.rd_timeout  = timeout_q;

endmodule

// File: tb/tb_const_issue_stage.sv
// Self-checking bench for const_issue_stage: directed cases followed by random instructions,
// each checked cycle by cycle against a transaction-level model of the stage.
module tb_const_issue_stage;

    localparam int RD_TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    const_issue_stage_if #(.bits_palavra(16), .REG_ADDR_W(3)) bus ();

    const_issue_stage dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Constant the ALU should see, from the encoding rules.
    function automatic logic [15:0] ref_const(input logic [15:0] ins);
        int v;
        if (ins[15:14] == 2'b01) begin
            v = int'(ins[10:0]);
            if (v >= 1024) v = v - 2048;
            return 16'(v);
        end
        v = int'(ins[7:0]);
        return ins[10] ? 16'(v * 256) : 16'(v);
    endfunction

    // Drive one instruction from IDLE and follow it to completion.
    // ack_cycle: read-request cycle (1-based) in which ack is given; outside 1..15 means never.
    // stall: cycles op_ready stays low once the bundle is valid.
    task automatic run_instr(input logic [15:0] ins, input int ack_cycle, input int stall,
                             input logic [15:0] rdata);
        logic [1:0]  fmt = ins[15:14];
        logic [2:0]  rd = ins[13:11];
        logic [15:0] exp_dado;
        bit          issued;
        check("instr_ready_idle", bus.instr_ready, 1);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr       = 16'($urandom);
        if (fmt == 2'b00 || fmt == 2'b10) begin
            check("illegal_pulse", bus.illegal, 1);
            check("illegal_no_valid", bus.op_valid, 0);
            check("illegal_no_req", bus.rf_rd_req, 0);
            @(negedge clk);
            check("illegal_once", bus.illegal, 0);
            check("illegal_no_valid2", bus.op_valid, 0);
            check("illegal_no_req2", bus.rf_rd_req, 0);
            return;
        end
        exp_dado = 16'h0000;
        if (fmt == 2'b11) begin
            issued   = 1'b0;
            exp_dado = rdata;
            for (int k = 1; k <= RD_TIMEOUT; k++) begin
                check("rd_req", bus.rf_rd_req, 1);
                check("rd_addr", bus.rf_rd_addr, rd);
                check("rd_not_ready", bus.instr_ready, 0);
                check("rd_no_valid", bus.op_valid, 0);
                check("rd_no_timeout", bus.rd_timeout, 0);
                bus.op_ready   = 1'($urandom);  // must be ignored while nothing is valid
                bus.rf_rd_data = 16'($urandom);
                if (k == ack_cycle) begin
                    bus.rf_rd_ack  = 1'b1;
                    bus.rf_rd_data = rdata;
                    @(negedge clk);
                    bus.rf_rd_ack = 1'b0;
                    issued        = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            bus.op_ready = 1'b0;
            if (!issued) begin
                check("timeout_pulse", bus.rd_timeout, 1);
                check("timeout_no_valid", bus.op_valid, 0);
                check("timeout_no_req", bus.rf_rd_req, 0);
                check("timeout_ready", bus.instr_ready, 1);
                @(negedge clk);
                check("timeout_once", bus.rd_timeout, 0);
                check("timeout_no_valid2", bus.op_valid, 0);
                return;
            end
        end else begin
            check("lit_no_req", bus.rf_rd_req, 0);
        end
        for (int s = 0; s <= stall; s++) begin
            check("op_valid", bus.op_valid, 1);
            check("dado", bus.dado, exp_dado);
            check("constante", bus.constante, ref_const(ins));
            check("formato", bus.formato, fmt);
            check("dest", bus.dest, rd);
            if (fmt == 2'b11) check("R", bus.R, ins[10]);
            check("issue_not_ready", bus.instr_ready, 0);
            check("issue_no_req", bus.rf_rd_req, 0);
            check("issue_no_timeout", bus.rd_timeout, 0);
            bus.op_ready = (s == stall);
            @(negedge clk);
        end
        bus.op_ready = 1'b0;
        check("op_valid_drop", bus.op_valid, 0);
        check("ready_back", bus.instr_ready, 1);
    endtask

    initial begin
        bus.instr       = 16'h0000;
        bus.instr_valid = 1'b0;
        bus.rf_rd_ack   = 1'b0;
        bus.rf_rd_data  = 16'h0000;
        bus.op_ready    = 1'b0;

        // Reset state
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_op_valid", bus.op_valid, 0);
        check("rst_req", bus.rf_rd_req, 0);
        check("rst_illegal", bus.illegal, 0);
        check("rst_timeout", bus.rd_timeout, 0);
        check("rst_dado", bus.dado, 0);
        check("rst_constante", bus.constante, 0);
        check("rst_formato", bus.formato, 0);
        check("rst_R", bus.R, 0);
        check("rst_dest", bus.dest, 0);
        check("rst_addr", bus.rf_rd_addr, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", bus.instr_ready, 1);
        check("post_rst_valid", bus.op_valid, 0);

        // Load literal: imm -1 and +5
        run_instr({2'b01, 3'd2, 11'h7FF}, 0, 0, 16'h0000);
        run_instr({2'b01, 3'd3, 11'h005}, 0, 1, 16'h0000);
        // lcl with ack in the third request cycle
        run_instr({2'b11, 3'd5, 1'b0, 2'b00, 8'hAB}, 3, 0, 16'h1234);
        // lch, immediate ack, four cycles of backpressure
        run_instr({2'b11, 3'd6, 1'b1, 2'b11, 8'hCD}, 1, 4, 16'h5555);
        // Illegal formats
        run_instr({2'b00, 14'h1234}, 0, 0, 16'h0000);
        run_instr({2'b10, 14'h2ABC}, 0, 0, 16'h0000);
        // Timeout, then ack exactly in the last allowed cycle
        run_instr({2'b11, 3'd1, 1'b0, 2'b00, 8'h7E}, 0, 0, 16'hBEEF);
        run_instr({2'b11, 3'd7, 1'b1, 2'b00, 8'h81}, RD_TIMEOUT, 0, 16'hCAFE);

        // Reset while a register read is pending
        bus.instr       = {2'b11, 3'd4, 1'b0, 2'b00, 8'h11};
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check("pre_rst_req", bus.rf_rd_req, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", bus.op_valid, 0);
        check("midrst_req", bus.rf_rd_req, 0);
        check("midrst_ready", bus.instr_ready, 1);
        check("midrst_timeout", bus.rd_timeout, 0);
        check("midrst_illegal", bus.illegal, 0);
        run_instr({2'b01, 3'd0, 11'h400}, 0, 0, 16'h0000);

        // Random instructions, ack timing and backpressure
        for (int i = 0; i < 30; i++) begin
            run_instr(16'($urandom), int'($urandom_range(1, RD_TIMEOUT + 2)),
                      int'($urandom_range(0, 3)), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
